// File: rtl/nn_pkg.sv
// Shared types and helpers for the neuron datapath (MAC controller and saturating shifter).
package nn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } nn_mac_state_t;

    localparam int NN_DW    = 8;
    localparam int NN_FRAC  = 4;
    localparam int NN_OUT_W = 8;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nn_sat_shift.sv
// Combinational rescale of a wide accumulator to output format: arithmetic shift, clamp,
// and optional ReLU (negative results forced to zero when RELU != 0).
module nn_sat_shift
    import nn_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int OUT_W = NN_OUT_W,
    parameter int FRAC  = NN_FRAC,
    parameter bit RELU  = 1'b0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);

    logic signed [ACC_W-1:0] t;

    // Arithmetic shift gives floor rounding on negative values.
    assign t = acc >>> FRAC;

    always_comb begin
        y = t[OUT_W-1:0];
        if (RELU && (t < 0)) begin
            y = '0;
        end else if (t > MAX_V) begin
            y = MAX_V[OUT_W-1:0];
        end else if (t < MIN_V) begin
            y = MIN_V[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/nn_neuron_mac.sv
// Sequential multiply-accumulate neuron: one product per clock, then bias-aligned rescale.
// Define NEURON_RELU_EN to fuse a ReLU into the output rescale.
module nn_neuron_mac
    import nn_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DW    = NN_DW,
    parameter int FRAC  = NN_FRAC,
    parameter int ACC_W = 20,
    parameter int OUT_W = NN_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_IN*DW-1:0]       x_flat,
    input  logic [N_IN*DW-1:0]       w_flat,
    input  logic signed [DW-1:0]     bias,
    output logic                     ready,
    output logic                     busy,
    output logic signed [OUT_W-1:0]  y
);

    localparam int IDX_W = (N_IN > 1) ? clog2(N_IN) : 1;

`ifdef NEURON_RELU_EN
    localparam bit RELU_EN = 1'b1;
`else
    localparam bit RELU_EN = 1'b0;
`endif

    if (N_IN < 1) begin : g_chk_n_in
        $error("nn_neuron_mac: N_IN must be >= 1");
    end
    if (ACC_W < 2*DW + clog2(N_IN + 1)) begin : g_chk_acc_w
        $error("nn_neuron_mac: ACC_W too narrow for N_IN products plus bias");
    end

    nn_mac_state_t            state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic signed [DW-1:0]     x_reg [N_IN];
    logic signed [DW-1:0]     w_reg [N_IN];
    logic signed [DW-1:0]     x_in  [N_IN];
    logic signed [DW-1:0]     w_in  [N_IN];
    logic signed [2*DW-1:0]   prod;
    logic signed [OUT_W-1:0]  sat_y;

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
        assign x_in[gi] = x_flat[gi*DW +: DW];
        assign w_in[gi] = w_flat[gi*DW +: DW];
    end

    assign prod = x_reg[idx_reg] * w_reg[idx_reg];

    nn_sat_shift #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .FRAC  (FRAC),
        .RELU  (RELU_EN)
    ) u_sat_shift (
        .acc (acc_reg),
        .y   (sat_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            y         <= '0;
            acc_reg   <= '0;
            idx_reg   <= '0;
            for (int i = 0; i < N_IN; i++) begin
                x_reg[i] <= '0;
                w_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (en) begin
                        for (int i = 0; i < N_IN; i++) begin
                            x_reg[i] <= x_in[i];
                            w_reg[i] <= w_in[i];
                        end
                        // Bias pre-shifted so it lands on the 2*FRAC product scale.
                        acc_reg   <= ACC_W'(bias) <<< FRAC;
                        idx_reg   <= '0;
                        state_reg <= MAC;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACC_W'(prod);
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == IDX_W'(N_IN - 1)) begin
                        state_reg <= SCALE;
                    end
                end
                SCALE: begin
                    y         <= sat_y;
                    state_reg <= DONE;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed bench for nn_neuron_mac with default parameters (N_IN=3, DW=8, FRAC=4).
module tb_nn_neuron_mac;

    logic               clk;
    logic               rst;
    logic               en;
    logic [23:0]        x_flat;
    logic [23:0]        w_flat;
    logic signed [7:0]  bias;
    logic               ready;
    logic               busy;
    logic signed [7:0]  y;

    int checks;
    int errors;

    nn_neuron_mac dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .x_flat (x_flat),
        .w_flat (w_flat),
        .bias   (bias),
        .ready  (ready),
        .busy   (busy),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts negedge samples with ready low, bounded so a stuck DUT cannot hang the run.
    task automatic wait_ready(output int low_cycles);
        low_cycles = 0;
        while (ready !== 1'b1 && low_cycles < 20) begin
            low_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic load_default();
        x_flat = {8'sd16, 8'sd16, 8'sd16};
        w_flat = {-8'sd16, 8'sd32, 8'sd16};
        bias   = 8'sd16;
    endtask

    initial begin
        int n;
        int highs;
        int lows;
        int run_hi;
        int max_run_hi;
        logic signed [31:0] neg_exp;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        en  = 1'b0;
        load_default();
        repeat (3) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_busy", busy, 0);
        check("reset_y", y, 0);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: 1*1 + 1*2 + 1*(-1) + 1 = 3.0 -> 48
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        check("s1_busy_high", busy, 1);
        wait_ready(n);
        check("s1_ready_low_cycles", n, 4);
        check("s1_y", y, 48);
        check("s1_busy_low", busy, 0);
        $display("txn default: y=%0d ready_low=%0d", y, n);

        // Positive saturation: acc = 50419, shifted 3151 -> 127
        x_flat = {8'sd127, 8'sd127, 8'sd127};
        w_flat = {8'sd127, 8'sd127, 8'sd127};
        bias   = 8'sd127;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_ready(n);
        check("pos_sat_cycles", n, 4);
        check("pos_sat_y", y, 127);
        $display("txn pos_sat: y=%0d", y);

        // Reset during the second MAC cycle clears outputs without a clock edge.
        load_default();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_y", y, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_ready(n);
        check("midrst_rerun_y", y, 48);
        $display("txn reset_rerun: y=%0d", y);

        // Negative saturation: acc = -50435 -> -3153 -> -128 (0 with fused ReLU)
        x_flat = {8'sd127, 8'sd127, 8'sd127};
        w_flat = {-8'sd127, -8'sd127, -8'sd127};
        bias   = -8'sd128;
`ifdef NEURON_RELU_EN
        neg_exp = 0;
`else
        neg_exp = -128;
`endif
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_ready(n);
        check("neg_sat_y", y, neg_exp);
        $display("txn neg_sat: y=%0d", y);

        // en repeated during MAC with different x must not disturb the result.
        load_default();
        en = 1'b1;
        @(negedge clk);
        check("ign_ready_low", ready, 0);
        x_flat = {8'sd32, 8'sd32, 8'sd32};
        @(negedge clk);
        en = 1'b0;
        wait_ready(n);
        check("ign_ready_low_cycles", n + 1, 4);
        check("ign_y", y, 48);
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready !== 1'b1) lows++;
        end
        check("ign_single_rise", lows, 0);
        $display("txn en_ignored: y=%0d", y);

        // en held high: one ready-high cycle every 5 cycles, y=48 each time.
        load_default();
        en = 1'b1;
        highs = 0;
        run_hi = 0;
        max_run_hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                highs++;
                run_hi++;
                if (run_hi > max_run_hi) max_run_hi = run_hi;
                check("cont_y", y, 48);
            end else begin
                run_hi = 0;
            end
        end
        en = 1'b0;
        check("cont_results", highs, 3);
        check("cont_ready_pulse_width", max_run_hi, 1);
        wait_ready(n);
        check("cont_final_ready", ready, 1);
        $display("txn continuous: results=%0d", highs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
